// File: rtl/rc_pkg.sv
// Shared types and ALU opcodes for the reverse-converter micro-op sequencer.
package rc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ALU   = 2'd2
  } rc_state_e;

  typedef enum logic [2:0] {
    G0 = 3'd0, G1 = 3'd1, G2 = 3'd2, G3 = 3'd3,
    G4 = 3'd4, G5 = 3'd5, G6 = 3'd6, G7 = 3'd7
  } rc_grp_e;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;

  // G1..G3 rebuild by shifting left, G4..G7 by shifting right.
  function automatic logic grp_shifts_left(input rc_grp_e g);
    return (g == G1) || (g == G2) || (g == G3);
  endfunction

  function automatic logic grp_uses_sub(input rc_grp_e g);
    return (g == G1) || (g == G3);
  endfunction

endpackage

// File: rtl/rc_group_classify.sv
// Combinational classifier: maps a signed operand pair onto reconstruction group G0..G7.
module rc_group_classify
  import rc_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N+1:0] a_i,
  input  logic [N+1:0] b_i,
  output rc_grp_e      grp_o
);

  localparam logic [N+1:0] NEG_2N = {2'b11, {N{1'b0}}};
  localparam logic [N+1:0] POS_2N = {2'b01, {N{1'b0}}};
  localparam logic [N+1:0] NEG_2  = {{(N+1){1'b1}}, 1'b0};

  logic       neg_a, pos_a, z_b, n2_b;
  logic [1:0] m_a, m_b;
  logic [3:0] flags;

  assign neg_a = (a_i == NEG_2N);
  assign pos_a = (a_i == POS_2N);
  assign z_b   = (b_i == '0);
  assign n2_b  = (b_i == NEG_2);
  assign m_a   = a_i[N+1:N];
  assign m_b   = b_i[N+1:N];
  assign flags = {neg_a, z_b, pos_a, n2_b};

  always_comb begin
    grp_o = G0;
    if (a_i[0] != b_i[0]) begin
      grp_o = G0;
    end else if (a_i[0]) begin
      grp_o = m_a[1] ? G1 : G3;
    end else begin
      // Even operands: special-value flags take priority over the MSB pair.
      case (flags)
        4'b1100: grp_o = G0;
        4'b1000: grp_o = m_b[1] ? G4 : G0;
        4'b0100: begin
          if (m_a == 2'b10)                         grp_o = G4;
          else if (m_a == 2'b00 || m_a == 2'b11)    grp_o = G0;
          else                                      grp_o = G5;
        end
        4'b0011: grp_o = G6;
        4'b0010: grp_o = m_b[1] ? G6 : G5;
        4'b0001: begin
          if (m_a == 2'b01)                         grp_o = G5;
          else if (m_a == 2'b00 || m_a == 2'b11)    grp_o = G6;
          else                                      grp_o = G4;
        end
        4'b1001: grp_o = G4;
        default: begin
          casez ({m_a, m_b})
            4'b000?, 4'b110?: grp_o = G0;
            4'b011?:          grp_o = G2;
            4'b101?:          grp_o = G4;
            4'b010?:          grp_o = G5;
            4'b001?, 4'b111?: grp_o = G6;
            default:          grp_o = G7;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/rc_uop_sequencer.sv
// Accepts one operand pair, then issues bounded shift micro-ops followed by one ALU micro-op.
module rc_uop_sequencer
  import rc_pkg::*;
#(
  parameter int N   = 3,
  parameter int SHW = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N+1:0]   a_i,
  input  logic [N+1:0]   b_i,
  output logic           uop_valid_o,
  input  logic           uop_ready_i,
  output logic [2:0]     uop_sel_o,
  output logic [3:0]     uop_alu_o,
  output logic [SHW-1:0] uop_shamt_o,
  output logic           uop_shdir_o,
  output logic           uop_last_o,
  output logic           busy_o
);

  localparam int RW     = $clog2(N + 1);
  localparam int MAX_SH = (1 << SHW) - 1;
  localparam int CW     = (RW > SHW) ? RW : SHW;

  rc_state_e      state_q, state_d;
  rc_grp_e        sel_q, sel_d;
  rc_grp_e        grp;
  logic [RW-1:0]  rem_q, rem_d;
  logic [CW-1:0]  rem_w, sh_w;

  rc_group_classify #(.N(N)) u_classify (
    .a_i   (a_i),
    .b_i   (b_i),
    .grp_o (grp)
  );

  // Shift step is the remainder clamped to the per-op limit; never exceeds rem_q.
  assign rem_w = CW'(rem_q);
  assign sh_w  = (rem_w > CW'(MAX_SH)) ? CW'(MAX_SH) : rem_w;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rem_d       = rem_q;
    in_ready_o  = 1'b0;
    uop_valid_o = 1'b0;
    uop_alu_o   = ALU_ADD;
    uop_shamt_o = '0;
    uop_shdir_o = 1'b1;
    uop_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          sel_d   = grp;
          rem_d   = RW'(N);
          state_d = (grp == G0) ? ALU : SHIFT;
        end
      end
      SHIFT: begin
        uop_valid_o = 1'b1;
        uop_alu_o   = ALU_PASS;
        uop_shamt_o = sh_w[SHW-1:0];
        uop_shdir_o = grp_shifts_left(sel_q);
        if (uop_ready_i) begin
          rem_d = rem_q - sh_w[RW-1:0];
          if (rem_d == '0) state_d = ALU;
        end
      end
      ALU: begin
        uop_valid_o = 1'b1;
        uop_alu_o   = grp_uses_sub(sel_q) ? ALU_SUB : ALU_ADD;
        uop_last_o  = 1'b1;
        if (uop_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= G0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
    end
  end

  assign uop_sel_o = sel_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_rc_uop_sequencer.sv
// Directed bench for rc_uop_sequencer: one instance at N=3/SHW=3, one at N=5/SHW=2.
module tb_rc_uop_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=3, SHW=3 instance
  logic       rst3, iv3, ir3, uv3, ur3, dir3, last3, busy3;
  logic [4:0] a3, b3;
  logic [2:0] sel3, sh3;
  logic [3:0] alu3;
  wire [12:0] u3 = {uv3, sel3, alu3, sh3, dir3, last3};

  // N=5, SHW=2 instance
  logic       rst5, iv5, ir5, uv5, ur5, dir5, last5, busy5;
  logic [6:0] a5, b5;
  logic [2:0] sel5;
  logic [1:0] sh5;
  logic [3:0] alu5;
  wire [11:0] u5 = {uv5, sel5, alu5, sh5, dir5, last5};

  int pass_cnt = 0;
  int tot_cnt  = 0;

  rc_uop_sequencer #(.N(3), .SHW(3)) dut3 (
    .clk_i(clk), .rst_i(rst3), .in_valid_i(iv3), .in_ready_o(ir3),
    .a_i(a3), .b_i(b3), .uop_valid_o(uv3), .uop_ready_i(ur3),
    .uop_sel_o(sel3), .uop_alu_o(alu3), .uop_shamt_o(sh3),
    .uop_shdir_o(dir3), .uop_last_o(last3), .busy_o(busy3)
  );

  rc_uop_sequencer #(.N(5), .SHW(2)) dut5 (
    .clk_i(clk), .rst_i(rst5), .in_valid_i(iv5), .in_ready_o(ir5),
    .a_i(a5), .b_i(b5), .uop_valid_o(uv5), .uop_ready_i(ur5),
    .uop_sel_o(sel5), .uop_alu_o(alu5), .uop_shamt_o(sh5),
    .uop_shdir_o(dir5), .uop_last_o(last5), .busy_o(busy5)
  );

  // Classification vectors for N=3 (5-bit operands) with hand-derived groups.
  logic [4:0] ta [14] = '{5'd1, 5'd10, 5'b11000, 5'b01000, 5'b10100, 5'd12, 5'd4,
                          5'b11000, 5'b01000, 5'b11101, 5'b10100, 5'd3, 5'b11000, 5'd10};
  logic [4:0] tb [14] = '{5'd2, 5'b11010, 5'd4, 5'b11110, 5'd0, 5'd0, 5'b11100,
                          5'b11110, 5'd4, 5'd7, 5'd2, 5'b11111, 5'b11100, 5'b11110};
  logic [2:0] tg [14] = '{3'd0, 3'd2, 3'd0, 3'd6, 3'd4, 3'd5, 3'd6,
                          3'd4, 3'd5, 3'd1, 3'd7, 3'd3, 3'd4, 3'd5};

  task automatic test_reset();
    rst3 = 1'b1; rst5 = 1'b1; iv3 = 1'b0; iv5 = 1'b0; ur3 = 1'b0; ur5 = 1'b0;
    a3 = '0; b3 = '0; a5 = '0; b5 = '0;
    repeat (2) @(negedge clk);
    rst3 = 1'b0; rst5 = 1'b0;
    tot_cnt++;
    if (u3 !== 13'b0_000_0010_000_1_0) $display("FAIL reset_uop3 got=%b exp=%b", u3, 13'b0_000_0010_000_1_0);
    else pass_cnt++;
    tot_cnt++;
    if ({ir3, busy3} !== 2'b10) $display("FAIL reset_rdy3 got=%b exp=10", {ir3, busy3});
    else pass_cnt++;
    tot_cnt++;
    if (u5 !== 12'b0_000_0010_00_1_0) $display("FAIL reset_uop5 got=%b exp=%b", u5, 12'b0_000_0010_00_1_0);
    else pass_cnt++;
    tot_cnt++;
    if ({ir5, busy5} !== 2'b10) $display("FAIL reset_rdy5 got=%b exp=10", {ir5, busy5});
    else pass_cnt++;
  endtask

  task automatic test_g3_stream();
    @(negedge clk);
    ur3 = 1'b1; a3 = 5'd5; b3 = 5'd3; iv3 = 1'b1;
    #1;
    tot_cnt++;
    if ({uv3, ir3} !== 2'b01) $display("FAIL g3_accept got=%b exp=01", {uv3, ir3});
    else pass_cnt++;
    @(negedge clk);
    iv3 = 1'b0;
    tot_cnt++;
    if (u3 !== 13'b1_011_0000_011_1_0) $display("FAIL g3_shift got=%b exp=%b", u3, 13'b1_011_0000_011_1_0);
    else pass_cnt++;
    tot_cnt++;
    if ({ir3, busy3} !== 2'b01) $display("FAIL g3_busy got=%b exp=01", {ir3, busy3});
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (u3 !== 13'b1_011_0110_000_1_1) $display("FAIL g3_alu got=%b exp=%b", u3, 13'b1_011_0110_000_1_1);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({ir3, busy3, uv3} !== 3'b100) $display("FAIL g3_done got=%b exp=100", {ir3, busy3, uv3});
    else pass_cnt++;
  endtask

  task automatic test_g0_direct();
    @(negedge clk);
    ur3 = 1'b1; a3 = 5'b11000; b3 = 5'd0; iv3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
    tot_cnt++;
    if ({u3, ir3} !== 14'b1_000_0010_000_1_1_0) $display("FAIL g0_alu got=%b exp=%b", {u3, ir3}, 14'b1_000_0010_000_1_1_0);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({ir3, uv3} !== 2'b10) $display("FAIL g0_ready_back got=%b exp=10", {ir3, uv3});
    else pass_cnt++;
  endtask

  task automatic test_n5_g4();
    @(negedge clk);
    ur5 = 1'b1; a5 = 7'b1100000; b5 = 7'b1111110; iv5 = 1'b1;
    @(negedge clk);
    iv5 = 1'b0;
    tot_cnt++;
    if (u5 !== 12'b1_100_0000_11_0_0) $display("FAIL n5_shift1 got=%b exp=%b", u5, 12'b1_100_0000_11_0_0);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (u5 !== 12'b1_100_0000_10_0_0) $display("FAIL n5_shift2 got=%b exp=%b", u5, 12'b1_100_0000_10_0_0);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (u5 !== 12'b1_100_0010_00_1_1) $display("FAIL n5_alu got=%b exp=%b", u5, 12'b1_100_0010_00_1_1);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({uv5, ir5} !== 2'b01) $display("FAIL n5_done got=%b exp=01", {uv5, ir5});
    else pass_cnt++;
  endtask

  task automatic test_stall();
    @(negedge clk);
    ur5 = 1'b0; a5 = 7'b1100000; b5 = 7'b1111110; iv5 = 1'b1;
    @(negedge clk);
    iv5 = 1'b0;
    tot_cnt++;
    if (u5 !== 12'b1_100_0000_11_0_0) $display("FAIL stall_first got=%b exp=%b", u5, 12'b1_100_0000_11_0_0);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tot_cnt++;
      if (u5 !== 12'b1_100_0000_11_0_0) $display("FAIL stall_hold%0d got=%b exp=%b", i, u5, 12'b1_100_0000_11_0_0);
      else pass_cnt++;
    end
    ur5 = 1'b1;
    @(negedge clk);
    tot_cnt++;
    if (u5 !== 12'b1_100_0000_10_0_0) $display("FAIL stall_resume got=%b exp=%b", u5, 12'b1_100_0000_10_0_0);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (u5 !== 12'b1_100_0010_00_1_1) $display("FAIL stall_alu got=%b exp=%b", u5, 12'b1_100_0010_00_1_1);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({uv5, ir5} !== 2'b01) $display("FAIL stall_done got=%b exp=01", {uv5, ir5});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ur3 = 1'b0; a3 = 5'd5; b3 = 5'd3; iv3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
    tot_cnt++;
    if (u3 !== 13'b1_011_0000_011_1_0) $display("FAIL rstmid_shift got=%b exp=%b", u3, 13'b1_011_0000_011_1_0);
    else pass_cnt++;
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    tot_cnt++;
    if ({uv3, ir3, busy3, last3} !== 4'b0100) $display("FAIL rstmid_ctl got=%b exp=0100", {uv3, ir3, busy3, last3});
    else pass_cnt++;
    tot_cnt++;
    if (u3 !== 13'b0_000_0010_000_1_0) $display("FAIL rstmid_uop got=%b exp=%b", u3, 13'b0_000_0010_000_1_0);
    else pass_cnt++;
    ur3 = 1'b1; a3 = 5'b11101; b3 = 5'd1; iv3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
    tot_cnt++;
    if (u3 !== 13'b1_001_0000_011_1_0) $display("FAIL rstmid_new_shift got=%b exp=%b", u3, 13'b1_001_0000_011_1_0);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (u3 !== 13'b1_001_0110_000_1_1) $display("FAIL rstmid_new_alu got=%b exp=%b", u3, 13'b1_001_0110_000_1_1);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({uv3, ir3} !== 2'b01) $display("FAIL rstmid_new_done got=%b exp=01", {uv3, ir3});
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    @(negedge clk);
    ur3 = 1'b0; a3 = 5'd2; b3 = 5'b11010; iv3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
    tot_cnt++;
    if (u3 !== 13'b1_110_0000_011_0_0) $display("FAIL busy_shift got=%b exp=%b", u3, 13'b1_110_0000_011_0_0);
    else pass_cnt++;
    a3 = 5'd5; b3 = 5'd3; iv3 = 1'b1;
    @(negedge clk);
    tot_cnt++;
    if (u3 !== 13'b1_110_0000_011_0_0) $display("FAIL busy_hold got=%b exp=%b", u3, 13'b1_110_0000_011_0_0);
    else pass_cnt++;
    ur3 = 1'b1;
    @(negedge clk);
    tot_cnt++;
    if (u3 !== 13'b1_110_0010_000_1_1) $display("FAIL busy_alu got=%b exp=%b", u3, 13'b1_110_0010_000_1_1);
    else pass_cnt++;
    iv3 = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if ({uv3, ir3} !== 2'b01) $display("FAIL busy_done got=%b exp=01", {uv3, ir3});
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({uv3, ir3} !== 2'b01) $display("FAIL busy_no_extra got=%b exp=01", {uv3, ir3});
    else pass_cnt++;
  endtask

  task automatic test_classify();
    logic [2:0]  g;
    logic        dir;
    logic [3:0]  alu;
    logic [12:0] exp;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ur3 = 1'b1; a3 = ta[i]; b3 = tb[i]; iv3 = 1'b1;
      @(negedge clk);
      iv3 = 1'b0;
      g   = tg[i];
      dir = (g >= 3'd1) && (g <= 3'd3);
      alu = (g == 3'd1 || g == 3'd3) ? 4'b0110 : 4'b0010;
      if (g != 3'd0) begin
        exp = {1'b1, g, 4'b0000, 3'd3, dir, 1'b0};
        tot_cnt++;
        if (u3 !== exp) $display("FAIL cls%0d_shift got=%b exp=%b", i, u3, exp);
        else pass_cnt++;
        @(negedge clk);
      end
      exp = {1'b1, g, alu, 3'd0, 1'b1, 1'b1};
      tot_cnt++;
      if (u3 !== exp) $display("FAIL cls%0d_alu got=%b exp=%b", i, u3, exp);
      else pass_cnt++;
      @(negedge clk);
      tot_cnt++;
      if ({uv3, ir3} !== 2'b01) $display("FAIL cls%0d_done got=%b exp=01", i, {uv3, ir3});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_g3_stream();
    test_g0_direct();
    test_n5_g4();
    test_stall();
    test_reset_mid();
    test_busy_ignore();
    test_classify();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
